// File: rtl/fofb_pkg.sv
// fofb_pkg: shared TDATA layout, FIFO word format and status counter widths
package fofb_pkg;
    localparam int TDATA_W = 128;
    localparam int FIFO_W  = TDATA_W + 1;
    localparam int S_LSB   = 0;
    localparam int Y_LSB   = 32;
    localparam int X_LSB   = 64;
    localparam int IDX_LSB = 96;
    localparam int CNT_W   = 16;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic               last;
        logic [TDATA_W-1:0] data;
    } fifo_word_t;

    // Index is zero-extended by the caller; bits above it stay zero as padding
    function automatic logic [TDATA_W-1:0] pack_tdata(input logic [31:0] idx, input logic [31:0] x,
                                                       input logic [31:0] y, input logic [31:0] s);
        logic [TDATA_W-1:0] t;
        t = '0;
        t[S_LSB+:32]   = s;
        t[Y_LSB+:32]   = y;
        t[X_LSB+:32]   = x;
        t[IDX_LSB+:32] = idx;
        return t;
    endfunction
endpackage

// File: rtl/fofb_sync_fifo.sv
// fofb_sync_fifo: synchronous first-word-fall-through FIFO; a push while full is
// accepted only when a pop happens in the same cycle.
module fofb_sync_fifo #(
    parameter int WIDTH = 129,
    parameter int AW    = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    logic [WIDTH-1:0] mem_q [2**AW];
    logic [AW:0]      wptr_q, rptr_q;
    logic             do_rd, do_wr;

    always_comb begin
        empty_o   = wptr_q == rptr_q;
        full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        do_rd     = rd_en_i & ~empty_o;
        do_wr     = wr_en_i & (~full_o | do_rd);
        rd_data_o = mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + 1'b1;
            if (do_rd) rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end
endmodule

// File: rtl/fofb_readout_packetizer.sv
// fofb_readout_packetizer: stages FOFB readout samples, tags the last one of each
// frame and streams them through a FIFO onto an AXI-stream master with status.
module fofb_readout_packetizer
    import fofb_pkg::*;
#(
    parameter int FOFB_INDEX_WIDTH = 9,
    parameter int FIFO_AW          = 9
) (
    input  logic                        sysClk,
    input  logic                        sysReset,
    input  logic                        readoutActive,
    input  logic [FOFB_INDEX_WIDTH-1:0] fofbDSPreadoutIndex,
    input  logic [31:0]                 fofbDSPreadoutX,
    input  logic [31:0]                 fofbDSPreadoutY,
    input  logic [31:0]                 fofbDSPreadoutS,
    input  logic                        fofbDSPreadoutValid,
    output logic                        M_TVALID,
    input  logic                        M_TREADY,
    output logic [TDATA_W-1:0]          M_TDATA,
    output logic                        M_TLAST,
    output logic [CNT_W-1:0]            frameCount,
    output logic [CNT_W-1:0]            dropCount,
    output logic                        orderError,
    input  logic                        clearStatus
);
    logic                        act_q;
    logic                        stg_vld_q, stg_vld_d;
    logic [TDATA_W-1:0]          stg_q, stg_d;
    logic                        wr_vld_q, wr_vld_d;
    fifo_word_t                  wr_q, wr_d;
    logic [FOFB_INDEX_WIDTH-1:0] prev_q, prev_d;
    logic                        first_q, first_d;
    logic                        err_q, err_d;
    cnt_t                        frm_q, frm_d, drop_q, drop_d;
    fifo_word_t                  rd_word;
    logic                        fall, pop, full, empty, drop, bad_order;

    always_comb begin
        fall      = act_q & ~readoutActive;
        // The staged sample leaves when displaced by a new one or closed by the frame end
        wr_vld_d  = (fofbDSPreadoutValid | fall) & stg_vld_q;
        wr_d      = '{last: fall, data: stg_q};
        stg_d     = fofbDSPreadoutValid ? pack_tdata(32'(fofbDSPreadoutIndex), fofbDSPreadoutX,
                                                     fofbDSPreadoutY, fofbDSPreadoutS) : stg_q;
        stg_vld_d = fofbDSPreadoutValid | (stg_vld_q & ~fall);
        // A sample coinciding with the frame end opens the next frame
        bad_order = fofbDSPreadoutValid & ~(first_q | fall) & (fofbDSPreadoutIndex <= prev_q);
        first_d   = fofbDSPreadoutValid ? 1'b0 : (fall | first_q);
        prev_d    = fofbDSPreadoutValid ? fofbDSPreadoutIndex : prev_q;
        M_TVALID  = ~empty;
        M_TDATA   = empty ? '0 : rd_word.data;
        M_TLAST   = ~empty & rd_word.last;
        pop       = M_TVALID & M_TREADY;
        drop      = wr_vld_q & full & ~pop;
        err_d     = clearStatus ? 1'b0 : (err_q | bad_order);
        drop_d    = clearStatus ? '0 : drop_q + cnt_t'(drop & ~&drop_q);
        frm_d     = frm_q + cnt_t'((pop & rd_word.last) | (drop & wr_q.last));
    end

    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            act_q     <= 1'b0;
            stg_vld_q <= 1'b0;
            stg_q     <= '0;
            wr_vld_q  <= 1'b0;
            wr_q      <= '0;
            prev_q    <= '0;
            first_q   <= 1'b1;
            err_q     <= 1'b0;
            frm_q     <= '0;
            drop_q    <= '0;
        end else begin
            act_q     <= readoutActive;
            stg_vld_q <= stg_vld_d;
            stg_q     <= stg_d;
            wr_vld_q  <= wr_vld_d;
            wr_q      <= wr_d;
            prev_q    <= prev_d;
            first_q   <= first_d;
            err_q     <= err_d;
            frm_q     <= frm_d;
            drop_q    <= drop_d;
        end
    end

    fofb_sync_fifo #(
        .WIDTH(FIFO_W),
        .AW   (FIFO_AW)
    ) u_fifo (
        .clk_i    (sysClk),
        .rst_i    (sysReset),
        .wr_en_i  (wr_vld_q),
        .wr_data_i(wr_q),
        .rd_en_i  (pop),
        .rd_data_o(rd_word),
        .full_o   (full),
        .empty_o  (empty)
    );

    assign frameCount = frm_q;
    assign dropCount  = drop_q;
    assign orderError = err_q;
endmodule

// File: tb/tb_fofb_readout_packetizer.sv
// tb_fofb_readout_packetizer: scoreboard bench; expected beats are queued as frames
// are driven and compared as the stream master hands them over.
module tb_fofb_readout_packetizer;
    localparam int IW = 9;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          act = 1'b0;
    logic [IW-1:0] idx_in = '0;
    logic [31:0]   x_in = '0, y_in = '0, s_in = '0;
    logic          vld = 1'b0;
    logic          M_TVALID, M_TREADY = 1'b1, M_TLAST, orderError, clr = 1'b0;
    logic [127:0]  M_TDATA;
    logic [15:0]   frameCount, dropCount;

    int total = 0;
    int bad = 0;
    logic [128:0] exp_q[$];
    logic [129:0] held;
    logic         stall_prev = 1'b0;

    always #5 clk = ~clk;

    fofb_readout_packetizer #(.FOFB_INDEX_WIDTH(IW), .FIFO_AW(AW)) dut (
        .sysClk(clk), .sysReset(rst), .readoutActive(act),
        .fofbDSPreadoutIndex(idx_in), .fofbDSPreadoutX(x_in), .fofbDSPreadoutY(y_in),
        .fofbDSPreadoutS(s_in), .fofbDSPreadoutValid(vld),
        .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TDATA(M_TDATA), .M_TLAST(M_TLAST),
        .frameCount(frameCount), .dropCount(dropCount), .orderError(orderError),
        .clearStatus(clr)
    );

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [128:0] beat(input int i, input logic last);
        logic [128:0] b;
        b = '0;
        b[128]     = last;
        b[96+:IW]  = i[IW-1:0];
        b[64+:32]  = 32'(i);
        b[32+:32]  = 32'(i + 'h100);
        b[0+:32]   = 32'(i + 'h200);
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic c);
        vld    = 1'b1;
        idx_in = i[IW-1:0];
        x_in   = 32'(i);
        y_in   = 32'(i + 'h100);
        s_in   = 32'(i + 'h200);
        clr    = c;
        tick();
        vld = 1'b0;
        clr = 1'b0;
        tick();
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain", 160'(exp_q.size()), 160'd0);
        tick();
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) check("stall_hold", {M_TVALID, M_TLAST, M_TDATA}, held);
            if (M_TVALID && M_TREADY) begin
                if (exp_q.size() == 0) check("extra_beat", M_TVALID, 1'b0);
                else check("beat", {M_TLAST, M_TDATA}, exp_q.pop_front());
            end
            stall_prev = M_TVALID && !M_TREADY;
            held       = {M_TVALID, M_TLAST, M_TDATA};
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        check("rst_tvalid", M_TVALID, 0);
        check("rst_tlast", M_TLAST, 0);
        check("rst_tdata", M_TDATA, 0);
        check("rst_frames", frameCount, 0);
        check("rst_drops", dropCount, 0);
        check("rst_order", orderError, 0);
        rst = 1'b0;
        tick();

        // basic frame 0..3 with latency probes
        act = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(beat(i, i == 3));
        send(0, 0);
        check("staged_only", M_TVALID, 0);
        send(1, 0);
        check("lat_nonlast", {M_TVALID, M_TLAST, M_TDATA}, {1'b1, beat(0, 0)});
        send(2, 0);
        send(3, 0);
        repeat (4) tick();
        act = 1'b0;
        tick();
        check("last_early", M_TVALID, 0);
        tick();
        check("lat_last", {M_TVALID, M_TLAST, M_TDATA}, {1'b1, beat(3, 1)});
        drain();
        check("frames1", frameCount, 1);

        // same frame under a long stall
        M_TREADY = 1'b0;
        act = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(beat(i, i == 3));
        for (int i = 0; i < 4; i++) send(i, 0);
        act = 1'b0;
        repeat (10) tick();
        check("stall_valid", M_TVALID, 1);
        M_TREADY = 1'b1;
        drain();
        check("stall_drops", dropCount, 0);
        check("frames2", frameCount, 2);

        // overflow: depth 4, 8 samples, last one dropped
        M_TREADY = 1'b0;
        act = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(beat(i, 0));
        for (int i = 0; i < 8; i++) send(i, 0);
        act = 1'b0;
        repeat (3) tick();
        check("ovf_drops", dropCount, 4);
        M_TREADY = 1'b1;
        drain();
        check("ovf_frames", frameCount, 3);

        // ordering
        pulse_clear();
        check("drop_clr", dropCount, 0);
        act = 1'b1;
        exp_q.push_back(beat(5, 0));
        exp_q.push_back(beat(7, 0));
        exp_q.push_back(beat(6, 1));
        send(5, 0);
        send(7, 0);
        send(6, 0);
        act = 1'b0;
        tick();
        drain();
        check("order_set", orderError, 1);
        pulse_clear();
        check("order_clr", orderError, 0);
        act = 1'b1;
        exp_q.push_back(beat(3, 0));
        exp_q.push_back(beat(2, 1));
        send(3, 0);
        send(2, 1);
        check("clr_priority", orderError, 0);
        act = 1'b0;
        tick();
        drain();
        act = 1'b1;
        exp_q.push_back(beat(0, 0));
        exp_q.push_back(beat(1, 1));
        send(0, 0);
        send(1, 0);
        act = 1'b0;
        tick();
        drain();
        check("order_first_exempt", orderError, 0);
        check("frames6", frameCount, 6);

        // sample while inactive is flushed on the next falling edge
        exp_q.push_back(beat(9, 1));
        send(9, 0);
        check("idle_staged", M_TVALID, 0);
        act = 1'b1;
        repeat (2) tick();
        act = 1'b0;
        repeat (2) tick();
        drain();
        check("frames7", frameCount, 7);

        // reset mid-frame
        M_TREADY = 1'b0;
        act = 1'b1;
        send(0, 0);
        send(1, 0);
        check("pre_rst_tvalid", M_TVALID, 1);
        rst = 1'b1;
        exp_q.delete();
        tick();
        check("mid_rst_tvalid", M_TVALID, 0);
        check("mid_rst_tlast", M_TLAST, 0);
        check("mid_rst_tdata", M_TDATA, 0);
        check("mid_rst_frames", frameCount, 0);
        check("mid_rst_drops", dropCount, 0);
        check("mid_rst_order", orderError, 0);
        rst = 1'b0;
        M_TREADY = 1'b1;
        exp_q.push_back(beat(2, 0));
        exp_q.push_back(beat(3, 1));
        send(2, 0);
        send(3, 0);
        act = 1'b0;
        tick();
        drain();
        check("post_rst_frames", frameCount, 1);

        // empty frames
        for (int k = 0; k < 3; k++) begin
            act = 1'b1;
            repeat (2) tick();
            act = 1'b0;
            repeat (3) tick();
            check("empty_tvalid", M_TVALID, 0);
        end
        check("empty_frames", frameCount, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
